// File: rtl/ps_led_ctrl_pkg.sv
// ps_led_pkg: shared encodings and field positions for the PS7 LED driver.
//   mode_e       : per-channel mode carried in cfg[MODE_HI:MODE_LO]
//   CFG_W/ARG_W  : config byte width and argument field width
//   BLINK_CNT_W  : width of the per-channel blink tick counter
//   BREATHE_STEP : ticks per duty step of the breathe triangle
//                  (used only when LED_BREATHE_EN is defined)
package ps_led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_PWM   = 2'b11
  } mode_e;

  localparam int CFG_W        = 8;
  localparam int MODE_HI      = 7;
  localparam int MODE_LO      = 6;
  localparam int ARG_W        = 6;
  localparam int PWM_W        = 6;
  localparam int BLINK_CNT_W  = 9;
  localparam int BREATHE_STEP = 4;

endpackage

// File: rtl/ps_led_ctrl_if.sv
// ps_led_if: software-facing bundle of the LED driver.
//   cfg_i    : NCH config bytes (master -> slave)
//   commit_i : commit toggle, asynchronous to clk (master -> slave)
//   ack_o    : commit level echoed once the config is applied
//   led_o    : registered LED drive
//   tick_o   : one-cycle pulse every PRESC clk cycles
interface ps_led_if #(parameter int NCH = 2);
  logic [NCH*8-1:0] cfg_i;
  logic             commit_i;
  logic             ack_o;
  logic [NCH-1:0]   led_o;
  logic             tick_o;

  modport master (output cfg_i, output commit_i,
                  input ack_o, input led_o, input tick_o);
  modport slave  (input cfg_i, input commit_i,
                  output ack_o, output led_o, output tick_o);
endinterface

// File: rtl/ps_led_ctrl_chan.sv
// ps_led_chan: one LED channel. Decodes the active config byte and holds the
// blink counter/phase (and breathe duty when LED_BREATHE_EN is defined).
//   clk, rst    : clock, asynchronous active-high reset
//   cfg_i       : active config byte ([7:6] mode, [5:0] arg)
//   tick_i      : prescaler tick
//   pwm_cnt_i   : shared 6-bit PWM phase
//   chg_i       : this channel's byte is being replaced on this edge
//   lit_o       : unregistered lit flag (polarity applied at the top)
// Optional feature macro: LED_BREATHE_EN (PWM arg=0 becomes a breathe ramp).
module ps_led_chan
  import ps_led_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [CFG_W-1:0] cfg_i,
  input  logic             tick_i,
  input  logic [PWM_W-1:0] pwm_cnt_i,
  input  logic             chg_i,
  output logic             lit_o
);

  mode_e                  mode;
  logic [ARG_W-1:0]       arg;
  logic [BLINK_CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic                   phase_q, phase_d;
  logic [BLINK_CNT_W-1:0] blink_last;
  logic [PWM_W-1:0]       pwm_ref;

  assign mode       = mode_e'(cfg_i[MODE_HI:MODE_LO]);
  assign arg        = cfg_i[ARG_W-1:0];
  // Last count of a half-period: (arg+1)*8-1 == {arg, 3'b111}
  assign blink_last = {arg, 3'b111};

  // A byte change wins over a coincident tick; outside BLINK the counter idles at 0.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (chg_i || mode != MODE_BLINK) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (tick_i) begin
      if (blink_cnt_q == blink_last) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

`ifdef LED_BREATHE_EN
  localparam int SUB_W = $clog2(BREATHE_STEP);

  logic [SUB_W-1:0] sub_q, sub_d;
  logic [PWM_W-1:0] duty_q, duty_d;
  logic             up_q, up_d;
  logic             breathe;

  assign breathe = (mode == MODE_PWM) && (arg == '0);

  // Triangle 0..63..0: direction flips as the duty lands on 63 or on 0.
  always_comb begin
    sub_d  = sub_q;
    duty_d = duty_q;
    up_d   = up_q;
    if (chg_i) begin
      sub_d  = '0;
      duty_d = '0;
      up_d   = 1'b1;
    end else if (breathe && tick_i) begin
      if (sub_q == SUB_W'(BREATHE_STEP - 1)) begin
        sub_d = '0;
        if (up_q) begin
          duty_d = duty_q + PWM_W'(1);
          if (duty_q == PWM_W'(62)) up_d = 1'b0;
        end else begin
          duty_d = duty_q - PWM_W'(1);
          if (duty_q == PWM_W'(1)) up_d = 1'b1;
        end
      end else begin
        sub_d = sub_q + SUB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sub_q  <= '0;
      duty_q <= '0;
      up_q   <= 1'b1;
    end else begin
      sub_q  <= sub_d;
      duty_q <= duty_d;
      up_q   <= up_d;
    end
  end

  assign pwm_ref = breathe ? duty_q : arg;
`else
  // arg=0 compares pwm < 0, which is never true: constantly dark.
  assign pwm_ref = arg;
`endif

  always_comb begin
    lit_o = 1'b0;
    case (mode)
      MODE_OFF:   lit_o = 1'b0;
      MODE_ON:    lit_o = 1'b1;
      MODE_BLINK: lit_o = ~phase_q;
      MODE_PWM:   lit_o = (pwm_cnt_i < pwm_ref);
      default:    lit_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/ps_led_ctrl.sv
// ps_led_ctrl: multi-channel LED driver between PS7 GPIO and board LEDs.
//   clk : single clock domain      rst : asynchronous active-high reset
//   bus : ps_led_if slave (cfg_i, commit_i in; ack_o, led_o, tick_o out)
// Holds the commit synchroniser/latch, tick prescaler, shared PWM phase
// counter and the polarity-corrected LED output register.
// Optional feature macro: LED_BREATHE_EN (handled inside ps_led_chan).
module ps_led_ctrl
  import ps_led_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int PRESC   = 25000,
  parameter int PWM_DIV = 16,
  parameter int POL     = 1
)(
  input  logic     clk,
  input  logic     rst,
  ps_led_if.slave  bus
);

  localparam int PRESC_W = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int PDIV_W  = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [NCH-1:0] LED_DARK = (POL != 0) ? '0 : '1;

  logic [2:0]           sync_q, sync_d;
  logic                 commit_edge;
  logic                 ack_q, ack_d;
  logic [NCH*CFG_W-1:0] act_q, act_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic                 presc_wrap;
  logic                 tick_q, tick_d;
  logic [PDIV_W-1:0]    pdiv_q, pdiv_d;
  logic                 pdiv_wrap;
  logic [PWM_W-1:0]     pwm_q, pwm_d;
  logic [NCH-1:0]       led_q, led_d;
  logic [NCH-1:0]       lit;
  logic [NCH-1:0]       chg;

  // sync_q[1:0] is the synchroniser, sync_q[2] the edge-detect history.
  assign commit_edge = sync_q[2] ^ sync_q[1];
  assign presc_wrap  = (presc_q == PRESC_W'(PRESC - 1));
  assign pdiv_wrap   = (pdiv_q == PDIV_W'(PWM_DIV - 1));

  always_comb begin
    sync_d  = {sync_q[1:0], bus.commit_i};
    ack_d   = ack_q;
    act_d   = act_q;
    // cfg_i is held stable by software across the handshake, so it is
    // sampled directly on the synchronised commit edge.
    if (commit_edge) begin
      ack_d = sync_q[1];
      act_d = bus.cfg_i;
    end
    presc_d = presc_wrap ? '0 : presc_q + PRESC_W'(1);
    tick_d  = presc_wrap;
    pdiv_d  = pdiv_wrap ? '0 : pdiv_q + PDIV_W'(1);
    pwm_d   = pdiv_wrap ? pwm_q + PWM_W'(1) : pwm_q;
    led_d   = (POL != 0) ? lit : ~lit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      ack_q   <= 1'b0;
      act_q   <= '0;
      presc_q <= '0;
      tick_q  <= 1'b0;
      pdiv_q  <= '0;
      pwm_q   <= '0;
      led_q   <= LED_DARK;
    end else begin
      sync_q  <= sync_d;
      ack_q   <= ack_d;
      act_q   <= act_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      pdiv_q  <= pdiv_d;
      pwm_q   <= pwm_d;
      led_q   <= led_d;
    end
  end

  // Only channels whose byte actually changes restart their blink/breathe state.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    assign chg[gi] = commit_edge &&
                     (bus.cfg_i[gi*CFG_W +: CFG_W] != act_q[gi*CFG_W +: CFG_W]);

    ps_led_chan u_chan (
      .clk       (clk),
      .rst       (rst),
      .cfg_i     (act_q[gi*CFG_W +: CFG_W]),
      .tick_i    (tick_q),
      .pwm_cnt_i (pwm_q),
      .chg_i     (chg[gi]),
      .lit_o     (lit[gi])
    );
  end

  assign bus.ack_o  = ack_q;
  assign bus.led_o  = led_q;
  assign bus.tick_o = tick_q;

endmodule

// File: tb/tb_ps_led_ctrl.sv
module tb_ps_led_ctrl;

  localparam int NCH = 2;
  localparam int P   = 10;
  localparam int D   = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cfg;
  logic        commit;

  always #5 clk = ~clk;

  ps_led_if #(.NCH(NCH)) bus_h ();
  ps_led_if #(.NCH(NCH)) bus_l ();

  assign bus_h.cfg_i    = cfg;
  assign bus_h.commit_i = commit;
  assign bus_l.cfg_i    = cfg;
  assign bus_l.commit_i = commit;

  ps_led_ctrl #(.NCH(NCH), .PRESC(P), .PWM_DIV(D), .POL(1)) dut_h (
    .clk (clk), .rst (rst), .bus (bus_h));
  ps_led_ctrl #(.NCH(NCH), .PRESC(P), .PWM_DIV(D), .POL(0)) dut_l (
    .clk (clk), .rst (rst), .bus (bus_l));

  // Observed vector: {ack, tick, led} of the active-high DUT then the active-low DUT.
  logic [7:0] obs;
  assign obs = {bus_h.ack_o, bus_h.tick_o, bus_h.led_o,
                bus_l.ack_o, bus_l.tick_o, bus_l.led_o};

  localparam logic [7:0] RST_VEC = 8'b0_0_00_0_0_11;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: time since reset release in edges, plus per-channel
  // active byte and the edge at which it was entered.
  int          cyc;
  logic [7:0]  act   [NCH];
  int          entry [NCH];
  bit          pend;
  int          pend_l;
  logic [15:0] pend_cfg;
  logic        pend_lvl;
  logic        m_ack;
  logic [1:0]  exp_led;
  logic [7:0]  expv;

  task automatic model_reset();
    cyc   = 0;
    pend  = 0;
    m_ack = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      act[c]   = 8'h00;
      entry[c] = 0;
    end
  endtask

  // Lit state derived from the elapsed ticks/cycles since the mode was entered.
  function automatic logic model_lit(input int ch, input int m);
    int   arg, ntick, pwm, duty, s;
    logic res;
    arg   = int'(act[ch][5:0]);
    pwm   = (m / D) % 64;
    ntick = (entry[ch] >= 1 && m >= entry[ch]) ? ((m - 1) / P - (entry[ch] - 1) / P) : 0;
    duty  = arg;
`ifdef LED_BREATHE_EN
    if (arg == 0) begin
      s    = (ntick / 4) % 126;
      duty = (s <= 63) ? s : 126 - s;
    end
`else
    s = 0;
`endif
    case (act[ch][7:6])
      2'b00:   res = 1'b0;
      2'b01:   res = 1'b1;
      2'b10:   res = ((ntick / ((arg + 1) * 8)) % 2) == 0;
      default: res = pwm < duty;
    endcase
    return res;
  endfunction

  task automatic step();
    logic t;
    @(posedge clk);
    #1;
    cyc++;
    for (int c = 0; c < NCH; c++) exp_led[c] = model_lit(c, cyc - 1);
    if (pend && cyc == pend_l) begin
      for (int c = 0; c < NCH; c++) begin
        if (pend_cfg[c*8 +: 8] != act[c]) begin
          act[c]   = pend_cfg[c*8 +: 8];
          entry[c] = cyc;
        end
      end
      m_ack = pend_lvl;
      pend  = 0;
    end
    t    = (cyc % P == 0);
    expv = {m_ack, t, exp_led, m_ack, t, ~exp_led};
  endtask

  // Called right after an edge: the toggle precedes edge cyc+1, latch at cyc+3.
  task automatic toggle_commit(input logic [15:0] v);
    cfg      = v;
    commit   = ~commit;
    pend     = 1;
    pend_l   = cyc + 3;
    pend_cfg = v;
    pend_lvl = commit;
  endtask

  task automatic release_reset();
    cfg    = 16'h0000;
    commit = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    cfg    = 16'h0000;
    commit = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (obs !== RST_VEC) begin
      n_bad++;
      $display("FAIL reset_hold got=%b exp=%b", obs, RST_VEC);
    end
    release_reset();
    for (int i = 0; i < 25; i++) begin
      step();
      n_cmp++;
      if (obs !== expv) begin
        n_bad++;
        $display("FAIL reset_run cyc=%0d got=%b exp=%b", cyc, obs, expv);
      end
    end
  endtask

  task automatic test_commit_on();
    toggle_commit(16'h0040);
    for (int i = 0; i < 12; i++) begin
      step();
      n_cmp++;
      if (obs !== expv) begin
        n_bad++;
        $display("FAIL commit_on cyc=%0d got=%b exp=%b", cyc, obs, expv);
      end
    end
    n_cmp++;
    if (bus_h.led_o !== 2'b01 || bus_l.led_o !== 2'b10) begin
      n_bad++;
      $display("FAIL commit_on_led got=%b/%b exp=01/10", bus_h.led_o, bus_l.led_o);
    end
  endtask

  task automatic test_blink();
    toggle_commit(16'h0080);
    for (int i = 0; i < 400; i++) begin
      step();
      n_cmp++;
      if (obs !== expv) begin
        n_bad++;
        $display("FAIL blink cyc=%0d got=%b exp=%b", cyc, obs, expv);
      end
    end
    toggle_commit(16'h0081);
    for (int i = 0; i < 500; i++) begin
      step();
      n_cmp++;
      if (obs !== expv) begin
        n_bad++;
        $display("FAIL blink_recommit cyc=%0d got=%b exp=%b", cyc, obs, expv);
      end
    end
  endtask

  task automatic test_reset_mid();
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (obs !== RST_VEC) begin
      n_bad++;
      $display("FAIL reset_async got=%b exp=%b", obs, RST_VEC);
    end
    release_reset();
    for (int i = 0; i < 40; i++) begin
      step();
      n_cmp++;
      if (obs !== expv || bus_h.led_o !== 2'b00) begin
        n_bad++;
        $display("FAIL reset_after cyc=%0d got=%b exp=%b", cyc, obs, expv);
      end
    end
  endtask

  task automatic test_pwm();
    logic [15:0] vals [3];
    int          want [3];
    int          lit_cnt;
    vals[0] = 16'hD000; want[0] = 16;
    vals[1] = 16'hFF00; want[1] = 63;
    vals[2] = 16'hC000; want[2] = 0;
    for (int k = 0; k < 3; k++) begin
      toggle_commit(vals[k]);
      for (int i = 0; i < 10; i++) begin
        step();
        n_cmp++;
        if (obs !== expv) begin
          n_bad++;
          $display("FAIL pwm_settle cyc=%0d got=%b exp=%b", cyc, obs, expv);
        end
      end
      lit_cnt = 0;
      for (int i = 0; i < 64; i++) begin
        step();
        lit_cnt += int'(bus_h.led_o[1]);
        n_cmp++;
        if (obs !== expv) begin
          n_bad++;
          $display("FAIL pwm cyc=%0d got=%b exp=%b", cyc, obs, expv);
        end
      end
`ifndef LED_BREATHE_EN
      n_cmp++;
      if (lit_cnt != want[k]) begin
        n_bad++;
        $display("FAIL pwm_duty cfg=%h got=%0d exp=%0d", vals[k], lit_cnt, want[k]);
      end
`else
      if (k < 2) begin
        n_cmp++;
        if (lit_cnt != want[k]) begin
          n_bad++;
          $display("FAIL pwm_duty cfg=%h got=%0d exp=%0d", vals[k], lit_cnt, want[k]);
        end
      end
`endif
    end
  endtask

  task automatic test_no_commit();
    toggle_commit(16'h4180);
    for (int i = 0; i < 1000; i++) begin
      step();
      if (i > 10 && i % 100 == 0) cfg = 16'($urandom);
      n_cmp++;
      if (obs !== expv) begin
        n_bad++;
        $display("FAIL no_commit cyc=%0d got=%b exp=%b", cyc, obs, expv);
      end
    end
  endtask

`ifdef LED_BREATHE_EN
  task automatic test_breathe();
    toggle_commit(16'h00C0);
    for (int i = 0; i < 504 * P + 200; i++) begin
      step();
      n_cmp++;
      if (obs !== expv) begin
        n_bad++;
        $display("FAIL breathe cyc=%0d got=%b exp=%b", cyc, obs, expv);
      end
    end
  endtask
`endif

  task automatic test_random();
    logic [15:0] v;
    int          len;
    for (int r = 0; r < 10; r++) begin
      v = 16'($urandom);
      for (int c = 0; c < NCH; c++)
        if (v[c*8+7 -: 2] == 2'b10) v[c*8 +: 6] = v[c*8 +: 6] & 6'h03;
      toggle_commit(v);
      len = $urandom_range(50, 300);
      for (int i = 0; i < len; i++) begin
        step();
        n_cmp++;
        if (obs !== expv) begin
          n_bad++;
          $display("FAIL random cfg=%h cyc=%0d got=%b exp=%b", v, cyc, obs, expv);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    toggle_commit(16'h0080);
    for (int i = 0; i < 100; i++) begin
      step();
      n_cmp++;
      if (obs !== expv) begin
        n_bad++;
        $display("FAIL b2b_setup cyc=%0d got=%b exp=%b", cyc, obs, expv);
      end
    end
    // ch0 byte unchanged across both commits: its blink must run on undisturbed.
    toggle_commit(16'hD080);
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (obs !== expv) begin
        n_bad++;
        $display("FAIL b2b_first cyc=%0d got=%b exp=%b", cyc, obs, expv);
      end
    end
    toggle_commit(16'h4080);
    for (int i = 0; i < 300; i++) begin
      step();
      n_cmp++;
      if (obs !== expv) begin
        n_bad++;
        $display("FAIL b2b_second cyc=%0d got=%b exp=%b", cyc, obs, expv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_commit_on();
    test_blink();
    test_reset_mid();
    test_pwm();
    test_no_commit();
`ifdef LED_BREATHE_EN
    test_breathe();
`endif
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ps_led_ctrl.md
Name: ps_led_ctrl

Overview:
- Multi-channel LED driver placed between the PS7 GPIO outputs and the board LED pins.
- Replaces the direct GPIOO-to-LED wiring with per-channel modes: off, on, blink and PWM.
- Software writes one configuration byte per channel, then toggles a commit bit. An ack bit is returned on a PS7 GPIO input.
- Generalised in channel count, tick rate, PWM rate and output polarity.

Parameters:
- NCH, 2: number of LED channels.
- PRESC, 25000: clk cycles per tick (1 ms at 25 MHz).
- PWM_DIV, 16: clk cycles per PWM phase step.
- POL, 1: output polarity; 1 = active-high, 0 = active-low (led_o inverted).

Ports:
- clk  in  1  single clock domain (fclk-derived).
- rst  in  1  asynchronous, active-high reset.
- cfg_i  in  NCH*8  per-channel config; channel c uses bits [8c+7:8c].
- commit_i  in  1  commit toggle from PS GPIO; asynchronous to clk.
- ack_o  out  1  returns the commit_i level once the configuration is applied.
- led_o  out  NCH  registered LED drive.
- tick_o  out  1  one-cycle pulse every PRESC cycles.

Behaviour:
- Config byte layout: [7:6] mode, [5:0] arg. Modes: 00 OFF, 01 ON, 10 BLINK, 11 PWM.
- Reset values:
  - All active configs 0 (OFF); ack_o = 0; tick_o = 0.
  - Prescaler and PWM counter = 0; blink counters and phases = 0.
  - led_o = all LEDs dark, i.e. 0 when POL=1 and all-ones when POL=0.
- Commit handshake:
  - commit_i passes through a 2-FF synchroniser; a third FF provides edge detect (either edge).
  - If commit_i changes before edge k: the active config latches all of cfg_i at edge k+2, ack_o takes the new level at k+2, and led_o reflects the new config at k+3.
  - cfg_i is not synchronised. Software holds cfg_i stable from before the toggle until ack_o matches.
  - cfg_i changes without a commit toggle have no effect.
- Tick generation:
  - Counter runs 0..PRESC-1.
  - tick_o pulses for one cycle when the counter wraps to 0.
- PWM phase counter:
  - 6 bits, shared by all channels.
  - Increments every PWM_DIV cycles and wraps 63 -> 0.
- BLINK channel:
  - 9-bit counter advances on tick.
  - When the counter equals (arg+1)*8-1 it clears and the phase toggles. Half-period = (arg+1)*8 ticks.
  - Phase 0 = lit.
- PWM channel: lit while pwm_cnt < arg. arg=0 is never lit; arg=63 is lit 63/64.
- OFF: never lit. ON: always lit.
- Mode entry:
  - On any commit that changes a channel's byte, that channel's blink counter and phase clear to 0 on the latch edge.
  - Channels whose byte is unchanged keep running without a glitch.
  - A commit has priority over a simultaneous tick for the affected channel.
  - Outside BLINK mode the blink counter is held at 0.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). A commit in flight is lost, and software must re-toggle.

Optional Feature:
- Macro: LED_BREATHE_EN.
- Defined:
  - PWM mode with arg=0 selects BREATHE.
  - A per-channel 6-bit duty ramps up 0..63, then down 63..0, stepping every 4 ticks (triangle period 504 ticks).
  - Lit while pwm_cnt < duty.
  - Entering BREATHE via commit starts at duty 0, rising.
- Undefined: PWM arg=0 is constantly dark; the breathe logic is absent.

Decomposition:
- Package ps_led_pkg holds:
  - Mode encodings (MODE_OFF/ON/BLINK/PWM).
  - CFG_W=8, field positions MODE_HI/LO and ARG_W=6.
  - BLINK_CNT_W=9, BREATHE_STEP=4.
- Sub-module ps_led_chan, one instance per channel:
  - Inputs: active config byte, tick, pwm_cnt, change strobe.
  - Output: unregistered lit flag.
  - Holds the blink and breathe state.
- Top level holds the synchroniser, commit latch, prescaler, PWM counter and the polarity/output registers.

Test Plan:
1. Reset: assert rst mid-blink with POL=1 -> led_o=00, ack_o=0, tick_o=0 asynchronously. After release, led_o stays 00.
2. Commit ON:
   - Setup: cfg_i=16'h0040 (ch0 ON, ch1 OFF), toggle commit_i before edge k.
   - Expected: ack_o=1 at k+2, led_o=2'b01 at k+3.
   - Repeat with POL=0 -> led_o=2'b10.
3. Blink: PRESC=10, ch0 cfg=8'h80 (arg 0), commit -> led_o[0] lit for 80 cycles, dark for 80, repeating. Re-commit 8'h81 mid-phase -> restarts lit, half-period 160 cycles.
4. PWM: PWM_DIV=1, ch1 cfg=8'hD0 (arg 16) -> led_o[1] lit for exactly 16 of every 64 cycles. arg=63 -> 63/64. arg=0 -> never lit (macro off).
5. No-commit change: alter cfg_i without toggling commit_i -> led_o and ack_o unchanged for 1000 cycles.
6. Breathe (LED_BREATHE_EN defined):
   - Setup: PRESC=10, cfg=8'hC0.
   - Duty reaches 63 after 252 ticks, then returns to 0 at 504 ticks.
   - Lit count per 64-cycle PWM frame follows the duty.
